mem_io_responder: RTL and testbench

//   Target-side responder for the MemController byte bus. Serves one byte per access from a byte RAM
//   (1-cycle read latency) and decodes an IO window at 0x30000. Writes there feed a TX byte stream;

---
 rtl/mem_io_responder_pkg.sv | 24 ++
 rtl/mem_io_responder_byte_fifo.sv | 56 +++++
 rtl/mem_io_responder.sv | 153 +++++++++++++++
 tb/tb_mem_io_responder.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/mem_io_responder_pkg.sv
// Shared address-map constants and decode helpers for the MemController byte-bus responder.
// The optional RX stream path is enabled by the MEMIO_RX_EN macro, which is consumed in mem_io_responder.sv.
package mem_io_responder_pkg;

    localparam logic [31:0] IO_BASE     = 32'h0003_0000;
    localparam logic [15:0] IO_DATA_OFS = 16'h0000;
    localparam logic [15:0] IO_CTRL_OFS = 16'h0004;
    localparam logic [1:0]  IO_SEL_BITS = 2'b11;

    // Source of the byte currently presented on mem_dout.
    typedef enum logic {
        SRC_IO  = 1'b0,
        SRC_RAM = 1'b1
    } rd_src_e;

    function automatic logic is_io_addr(input logic [31:0] a);
        return a[17:16] == IO_SEL_BITS;
    endfunction

    function automatic logic [15:0] io_offset(input logic [31:0] a);
        return a[15:0] - IO_BASE[15:0];
    endfunction

endpackage

// File: rtl/mem_io_responder_byte_fifo.sv
// Byte-wide FIFO with global enable; pushes when full and pops when empty are ignored.
// Head byte is shown combinationally on dout, so a push becomes visible on the following cycle.
module mem_io_responder_byte_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     push,
    input  logic                     pop,
    input  logic [7:0]               din,
    output logic [7:0]               dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW:0]   count_q, count_d;
    logic          do_push, do_pop;

    assign full  = (count_q == (PW+1)'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign dout  = mem_q[rd_ptr_q];

    always_comb begin
        do_push  = en & push & ~full;
        do_pop   = en & pop & ~empty;
        wr_ptr_d = wr_ptr_q + PW'(do_push);
        rd_ptr_d = rd_ptr_q + PW'(do_pop);
        count_d  = count_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is data only and is never reset.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/mem_io_responder.sv
// Byte-bus target: byte RAM with registered read plus an IO window at 0x30000 (TX/RX byte streams, halt).
// Define MEMIO_RX_EN to build the RX FIFO; otherwise RX reads return 0 and rx_ready stays low.
module mem_io_responder
    import mem_io_responder_pkg::*;
#(
    parameter int ADDR_WIDTH = 17,
    parameter int TX_DEPTH   = 16,
    parameter int RX_DEPTH   = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        ram_enable,
    input  logic        lw_type,
    input  logic [31:0] addr,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic        io_buffer_full,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        sim_halt,
    output logic        tx_overflow
);

    localparam int TXW = $clog2(TX_DEPTH);

    logic [7:0] ram [2**ADDR_WIDTH];
    logic [7:0] ram_rdata_q;

    logic       access, io_sel;
    logic [15:0] ofs;
    logic       ram_wr, ram_rd, io_rd;
    logic       io_wr_data, io_wr_ctrl;
    logic       rx_pop;
    logic [ADDR_WIDTH-1:0] ram_idx;

    logic       sim_halt_q, sim_halt_d;
    logic       tx_overflow_q, tx_overflow_d;
    logic [7:0] io_rd_q, io_rd_d;
    rd_src_e    rd_src_q, rd_src_d;

    logic           tx_full, tx_empty;
    logic [TXW:0]   tx_count;
    logic           rx_nonempty;
    logic [7:0]     rx_head;

    logic unused_addr;
    assign unused_addr = ^addr[31:18];

    mem_io_responder_byte_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .en    (rdy),
        .push  (io_wr_data),
        .pop   (tx_ready & ~tx_empty),
        .din   (mem_din),
        .dout  (tx_data),
        .full  (tx_full),
        .empty (tx_empty),
        .count (tx_count)
    );

    assign tx_valid       = ~tx_empty;
    // Two-entry margin leaves room for one write already in flight when the controller sees this.
    assign io_buffer_full = (tx_count >= (TXW+1)'(TX_DEPTH - 2));

`ifdef MEMIO_RX_EN
    localparam int RXW = $clog2(RX_DEPTH);
    logic         rx_full, rx_empty;
    logic [RXW:0] rx_count;

    mem_io_responder_byte_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .en    (rdy),
        .push  (rx_valid),
        .pop   (rx_pop),
        .din   (rx_data),
        .dout  (rx_head),
        .full  (rx_full),
        .empty (rx_empty),
        .count (rx_count)
    );

    logic unused_rx;
    assign unused_rx   = ^rx_count;
    assign rx_ready    = ~rx_full;
    assign rx_nonempty = ~rx_empty;
`else
    logic unused_rx;
    assign unused_rx   = ^{rx_data, rx_valid, rx_pop, RX_DEPTH[0]};
    assign rx_ready    = 1'b0;
    assign rx_nonempty = 1'b0;
    assign rx_head     = 8'h00;
`endif

    always_comb begin
        access     = rdy & ram_enable;
        io_sel     = is_io_addr(addr);
        ofs        = io_offset(addr);
        ram_idx    = addr[ADDR_WIDTH-1:0];
        ram_wr     = access &  lw_type & ~io_sel;
        ram_rd     = access & ~lw_type & ~io_sel;
        io_rd      = access & ~lw_type &  io_sel;
        io_wr_data = access &  lw_type &  io_sel & (ofs == IO_DATA_OFS);
        io_wr_ctrl = access &  lw_type &  io_sel & (ofs == IO_CTRL_OFS);
        rx_pop     = io_rd & (ofs == IO_DATA_OFS);

        sim_halt_d    = rdy ? io_wr_ctrl : sim_halt_q;
        tx_overflow_d = tx_overflow_q | (io_wr_data & tx_full);

        rd_src_d = rd_src_q;
        if (ram_rd) rd_src_d = SRC_RAM;
        if (io_rd)  rd_src_d = SRC_IO;

        io_rd_d = io_rd_q;
        if (io_rd) begin
            if (ofs == IO_DATA_OFS)      io_rd_d = rx_nonempty ? rx_head : 8'h00;
            else if (ofs == IO_CTRL_OFS) io_rd_d = {6'b0, rx_nonempty, io_buffer_full};
            else                         io_rd_d = 8'h00;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sim_halt_q    <= 1'b0;
            tx_overflow_q <= 1'b0;
            io_rd_q       <= 8'h00;
            rd_src_q      <= SRC_IO;
        end else begin
            sim_halt_q    <= sim_halt_d;
            tx_overflow_q <= tx_overflow_d;
            io_rd_q       <= io_rd_d;
            rd_src_q      <= rd_src_d;
        end
    end

    // RAM array with a registered read port; the read register only moves on RAM reads.
    always_ff @(posedge clk) begin
        if (ram_wr) ram[ram_idx] <= mem_din;
        if (ram_rd) ram_rdata_q <= ram[ram_idx];
    end

    // Reset steers the output mux to the cleared IO byte, so a pending RAM result is dropped.
    assign mem_dout    = (rd_src_q == SRC_RAM) ? ram_rdata_q : io_rd_q;
    assign sim_halt    = sim_halt_q;
    assign tx_overflow = tx_overflow_q;

endmodule

// File: tb/tb_mem_io_responder.sv
// Directed bench for mem_io_responder: RAM access, address wrap, TX/RX streams, halt, rdy freeze, async reset.
module tb_mem_io_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        ram_enable;
    logic        lw_type;
    logic [31:0] addr;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic        io_buffer_full;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        sim_halt;
    logic        tx_overflow;

    int tests = 0;
    int fails = 0;

    mem_io_responder #(.ADDR_WIDTH(17), .TX_DEPTH(16), .RX_DEPTH(16)) dut (
        .clk            (clk),
        .rst            (rst),
        .rdy            (rdy),
        .ram_enable     (ram_enable),
        .lw_type        (lw_type),
        .addr           (addr),
        .mem_din        (mem_din),
        .mem_dout       (mem_dout),
        .io_buffer_full (io_buffer_full),
        .tx_data        (tx_data),
        .tx_valid       (tx_valid),
        .tx_ready       (tx_ready),
        .rx_data        (rx_data),
        .rx_valid       (rx_valid),
        .rx_ready       (rx_ready),
        .sim_halt       (sim_halt),
        .tx_overflow    (tx_overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One bus access strobed for a single cycle; on return the access edge is 1 time unit in the past.
    task automatic bus(input logic we, input logic [31:0] a, input logic [7:0] d);
        ram_enable = 1'b1;
        lw_type    = we;
        addr       = a;
        mem_din    = d;
        tick();
        ram_enable = 1'b0;
        lw_type    = 1'b0;
    endtask

    logic rx_on;
    logic [7:0] exp_byte;

    initial begin
`ifdef MEMIO_RX_EN
        rx_on = 1'b1;
`else
        rx_on = 1'b0;
`endif
        rst = 1'b1; rdy = 1'b1; ram_enable = 1'b0; lw_type = 1'b0;
        addr = '0; mem_din = '0; tx_ready = 1'b0; rx_data = '0; rx_valid = 1'b0;
        tick(); tick();

        chk("rst_mem_dout", mem_dout, 8'h00);
        chk("rst_tx_valid", tx_valid, 1'b0);
        chk("rst_sim_halt", sim_halt, 1'b0);
        chk("rst_tx_overflow", tx_overflow, 1'b0);
        chk("rst_ibf", io_buffer_full, 1'b0);
        chk("rst_rx_ready", rx_ready, rx_on);
        rst = 1'b0;
        tick();

        // 1: RAM write then read
        bus(1'b1, 32'h0000_0010, 8'hA5);
        bus(1'b0, 32'h0000_0010, 8'h00);
        chk("ram_rd_a5", mem_dout, 8'hA5);
        tick();
        chk("ram_rd_hold", mem_dout, 8'hA5);

        // 2: address wrap at ADDR_WIDTH=17
        bus(1'b1, 32'h0001_FFFF, 8'h34);
        bus(1'b1, 32'h0002_0000, 8'h12);
        bus(1'b0, 32'h0000_0000, 8'h00);
        chk("wrap_rd_0", mem_dout, 8'h12);
        bus(1'b0, 32'h0001_FFFF, 8'h00);
        chk("wrap_rd_1ffff", mem_dout, 8'h34);

        // 3: TX fill, back-pressure, overflow, drain
        chk("tx_empty_pre", tx_valid, 1'b0);
        for (int i = 0; i < 13; i++) bus(1'b1, 32'h0003_0000, 8'(8'h50 + i));
        chk("ibf_after_13", io_buffer_full, 1'b0);
        chk("tx_valid_13", tx_valid, 1'b1);
        bus(1'b1, 32'h0003_0000, 8'h5D);
        chk("ibf_after_14", io_buffer_full, 1'b1);
        bus(1'b1, 32'h0003_0000, 8'h5E);
        bus(1'b1, 32'h0003_0000, 8'h5F);
        chk("ovf_after_16", tx_overflow, 1'b0);
        bus(1'b1, 32'h0003_0000, 8'hEE);
        chk("ovf_after_17", tx_overflow, 1'b1);
        bus(1'b0, 32'h0003_0004, 8'h00);
        chk("status_tx_full", mem_dout, 8'h01);
        bus(1'b0, 32'h0000_0010, 8'h00);
        bus(1'b0, 32'h0003_0008, 8'h00);
        chk("io_other_ofs_rd", mem_dout, 8'h00);
        tx_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            exp_byte = 8'(8'h50 + i);
            chk($sformatf("tx_drain_v%0d", i), tx_valid, 1'b1);
            chk($sformatf("tx_drain_d%0d", i), tx_data, exp_byte);
            tick();
        end
        tx_ready = 1'b0;
        chk("tx_drained", tx_valid, 1'b0);
        chk("ibf_drained", io_buffer_full, 1'b0);
        chk("ovf_sticky", tx_overflow, 1'b1);

        // 4: RX stream
        chk("rx_ready_idle", rx_ready, rx_on);
        rx_valid = 1'b1; rx_data = 8'h41;
        tick();
        rx_data = 8'h42;
        tick();
        rx_valid = 1'b0; rx_data = 8'h00;
        bus(1'b0, 32'h0003_0004, 8'h00);
        chk("status_rx", mem_dout, rx_on ? 8'h02 : 8'h00);
        bus(1'b0, 32'h0003_0000, 8'h00);
        chk("rx_rd_1", mem_dout, rx_on ? 8'h41 : 8'h00);
        bus(1'b0, 32'h0003_0000, 8'h00);
        chk("rx_rd_2", mem_dout, rx_on ? 8'h42 : 8'h00);
        bus(1'b0, 32'h0003_0000, 8'h00);
        chk("rx_rd_empty", mem_dout, 8'h00);

        // 5: halt pulse and idle status
        chk("halt_pre", sim_halt, 1'b0);
        bus(1'b1, 32'h0003_0004, 8'h00);
        chk("halt_pulse", sim_halt, 1'b1);
        tick();
        chk("halt_clear", sim_halt, 1'b0);
        bus(1'b0, 32'h0003_0004, 8'h00);
        chk("status_idle", mem_dout, 8'h00);

        // 6: rdy freeze, then async reset with TX holding bytes
        bus(1'b0, 32'h0000_0010, 8'h00);
        chk("pre_freeze_rd", mem_dout, 8'hA5);
        rdy = 1'b0;
        bus(1'b1, 32'h0000_0010, 8'h77);
        chk("freeze_dout_hold", mem_dout, 8'hA5);
        bus(1'b1, 32'h0003_0000, 8'h99);
        chk("freeze_no_push", tx_valid, 1'b0);
        rdy = 1'b1;
        bus(1'b0, 32'h0000_0010, 8'h00);
        chk("freeze_ram_kept", mem_dout, 8'hA5);
        for (int i = 0; i < 5; i++) bus(1'b1, 32'h0003_0000, 8'(8'h60 + i));
        chk("tx5_valid", tx_valid, 1'b1);
        chk("tx5_head", tx_data, 8'h60);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_tx_valid", tx_valid, 1'b0);
        chk("async_rst_dout", mem_dout, 8'h00);
        chk("async_rst_ovf", tx_overflow, 1'b0);
        tick();
        rst = 1'b0;
        tick();
        chk("post_rst_tx_valid", tx_valid, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
